call_request_unit: RTL and testbench

Front-end request stage for the 3-floor elevator. It takes the raw interior (cab) and exterior (hall) call buttons and synchronises them, optionally debounces them, and edge-detects them. It then holds one pending-request bit per floor until the movement controller serves that floor. The `requests` vector it presents is the sole request source for the downstream movement FSM. Bit 0 = floor 1, bit 2 = floor 3 throughout.

---
 rtl/call_request_unit.sv | 109 ++++++++++
 tb/tb_call_request_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_request_unit.sv
// Elevator call request stage: synchronise, optionally debounce (CALL_DEBOUNCE_EN), edge-detect
// cab/hall buttons and hold one pending-request bit per floor until that floor is served.
module call_request_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] interior_panel,
    input  logic [2:0] exterior_panel,
    input  logic [1:0] current_floor,
    input  logic [2:0] doors,
    output logic [2:0] requests,
    output logic       req_valid,
    output logic       new_req,
    output logic [2:0] door_reopen,
    output logic [2:0] lamp
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 2..255");
    end

    // Bits [2:0] are cab buttons, [5:3] hall buttons.
    logic [5:0] raw;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] f;
    logic [5:0] f_d;
    logic [5:0] press_all;
    logic [2:0] press;
    logic [2:0] serve;
    logic [2:0] next_requests;

    assign raw = {exterior_panel, interior_panel};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef CALL_DEBOUNCE_EN
    localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt [6];

    // f flips on the DEBOUNCE_CYCLES-th consecutive edge with s2 != f.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            f <= '0;
            for (int i = 0; i < 6; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CntLast) begin
                    f[i]   <= ~f[i];
                    cnt[i] <= '0;
                end else if (cnt[i] != 8'hFF) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    assign f = s2;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            f_d <= '0;
        end else begin
            f_d <= f;
        end
    end

    assign press_all = f & ~f_d;
    assign press     = press_all[2:0] | press_all[5:3];

    // A floor is served only when doors is exactly its one-hot code and the cab is parked there.
    assign serve[0] = (doors == 3'b001) && (current_floor == 2'd1);
    assign serve[1] = (doors == 3'b010) && (current_floor == 2'd2);
    assign serve[2] = (doors == 3'b100) && (current_floor == 2'd3);

    assign next_requests = (requests | press) & ~serve;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            requests    <= '0;
            req_valid   <= 1'b0;
            new_req     <= 1'b0;
            door_reopen <= '0;
        end else begin
            requests    <= next_requests;
            req_valid   <= |next_requests;
            new_req     <= |(next_requests & ~requests);
            door_reopen <= press & serve;
        end
    end

    assign lamp = requests;

endmodule

// File: tb/tb_call_request_unit.sv
// Scoreboard bench for call_request_unit: stimulus queues expected output pulses, a monitor
// pops and compares them whenever new_req or door_reopen fires.
module tb_call_request_unit;

`ifdef CALL_DEBOUNCE_EN
    localparam int LAT = 6;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DEB = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] interior_panel = '0;
    logic [2:0] exterior_panel = '0;
    logic [1:0] current_floor = '0;
    logic [2:0] doors = '0;
    logic [2:0] requests;
    logic       req_valid;
    logic       new_req;
    logic [2:0] door_reopen;
    logic [2:0] lamp;

    call_request_unit #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .interior_panel(interior_panel),
        .exterior_panel(exterior_panel),
        .current_floor (current_floor),
        .doors         (doors),
        .requests      (requests),
        .req_valid     (req_valid),
        .new_req       (new_req),
        .door_reopen   (door_reopen),
        .lamp          (lamp)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] req;
        logic       nr;
        logic [2:0] dr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input logic [2:0] req, input logic nr, input logic [2:0] dr);
        exp_t e;
        e.cyc = c;
        e.req = req;
        e.nr  = nr;
        e.dr  = dr;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at(input int c);
        do @(negedge CLK); while (cyc < c);
    endtask

    task automatic serve1(input int fl);
        step();
        current_floor = 2'(fl);
        doors         = 3'(1 << (fl - 1));
        step();
        current_floor = '0;
        doors         = '0;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            chk("req_valid_vs_requests", 32'(req_valid), 32'(|requests));
            chk("lamp_vs_requests", 32'(lamp), 32'(requests));
        end
        if (new_req || door_reopen != 3'b000) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: new_req %0b door_reopen %03b requests %03b, none expected",
                         cyc, new_req, door_reopen, requests);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_requests", 32'(requests), 32'(e.req));
                chk("pulse_new_req", 32'(new_req), 32'(e.nr));
                chk("pulse_door_reopen", 32'(door_reopen), 32'(e.dr));
            end
        end
    end

    initial begin
        int n;
        // Reset with all cab buttons held.
        #1;
        RST = 1'b0;
        interior_panel = 3'b111;
        repeat (3) begin
            @(negedge CLK);
            chk("reset_requests", 32'(requests), 32'd0);
            chk("reset_flags", 32'({req_valid, new_req, door_reopen, lamp}), 32'd0);
        end
        step();
        RST = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b111, 1'b1, 3'b000);
        at(n + LAT);
        chk("reset_release_pre", 32'(requests), 32'd0);
        at(n + 1 + LAT);
        chk("reset_release_req", 32'(requests), 32'b111);
        chk("reset_release_valid", 32'(req_valid), 32'd1);
        step();
        interior_panel = '0;
        repeat (LAT + 2) step();
        serve1(1);
        serve1(2);
        serve1(3);
        @(negedge CLK);
        chk("cleared_all", 32'(requests), 32'd0);

        // Three-cycle glitch on hall floor 2.
        step();
        exterior_panel[1] = 1'b1;
        n = cyc;
        if (!DEB) push(n + 1 + LAT, 3'b010, 1'b1, 3'b000);
        repeat (3) step();
        exterior_panel[1] = 1'b0;
        at(n + 12);
        chk("glitch_requests", 32'(requests), DEB ? 32'd0 : 32'b010);
        serve1(2);

        // Sustained hall floor 2 press.
        step();
        exterior_panel[1] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b010, 1'b1, 3'b000);
        at(n + LAT);
        chk("press_pre", 32'(requests), 32'd0);
        at(n + 1 + LAT);
        chk("press_req", 32'(requests), 32'b010);
        step();
        exterior_panel[1] = 1'b0;
        repeat (LAT + 2) step();

        // Cab floor 3 press on top of pending floor 2.
        interior_panel[2] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b110, 1'b1, 3'b000);
        at(n + 1 + LAT);
        chk("two_floors", 32'(requests), 32'b110);
        step();
        interior_panel[2] = 1'b0;
        repeat (LAT + 2) step();

        // Malformed doors must not clear anything.
        current_floor = 2'd2;
        doors = 3'b110;
        step();
        current_floor = 2'd3;
        doors = 3'b010;
        step();
        current_floor = '0;
        doors = '0;
        @(negedge CLK);
        chk("bad_doors", 32'(requests), 32'b110);

        // Service clears in one cycle, req_valid aligned.
        step();
        current_floor = 2'd3;
        doors = 3'b100;
        step();
        current_floor = '0;
        doors = '0;
        @(negedge CLK);
        chk("serve3_req", 32'(requests), 32'b010);
        serve1(2);
        @(negedge CLK);
        chk("serve2_req", 32'(requests), 32'd0);
        chk("serve2_valid", 32'(req_valid), 32'd0);

        // Held button through service does not re-request.
        step();
        interior_panel[1] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b010, 1'b1, 3'b000);
        at(n + LAT + 3);
        serve1(2);
        @(negedge CLK);
        chk("held_cleared", 32'(requests), 32'd0);
        repeat (6) step();
        @(negedge CLK);
        chk("held_no_reset", 32'(requests), 32'd0);
        step();
        interior_panel[1] = 1'b0;
        repeat (LAT + 3) step();
        interior_panel[1] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b010, 1'b1, 3'b000);
        at(n + 1 + LAT);
        chk("repress", 32'(requests), 32'b010);
        step();
        interior_panel[1] = 1'b0;
        repeat (LAT + 2) step();
        serve1(2);

        // Press at the floor being served.
        step();
        current_floor = 2'd1;
        doors = 3'b001;
        interior_panel[0] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b000, 1'b0, 3'b001);
        at(n + 1 + LAT);
        chk("reopen_no_req", 32'(requests), 32'd0);
        step();
        interior_panel[0] = 1'b0;
        repeat (LAT + 2) step();
        current_floor = '0;
        doors = '0;
        repeat (2) step();
        @(negedge CLK);
        chk("reopen_after", 32'(requests), 32'd0);

        // Simultaneous presses while floor 2 is being served.
        step();
        exterior_panel[1] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b010, 1'b1, 3'b000);
        at(n + 1 + LAT);
        step();
        exterior_panel[1] = 1'b0;
        repeat (LAT + 2) step();
        interior_panel[2] = 1'b1;
        exterior_panel[0] = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b101, 1'b1, 3'b000);
        repeat (LAT) step();
        current_floor = 2'd2;
        doors = 3'b010;
        step();
        current_floor = '0;
        doors = '0;
        @(negedge CLK);
        chk("simul_req", 32'(requests), 32'b101);
        step();
        @(negedge CLK);
        chk("simul_hold", 32'(requests), 32'b101);

        // Asynchronous reset with buttons held, then fresh press after release.
        step();
        RST = 1'b0;
        #1;
        chk("async_reset_req", 32'(requests), 32'd0);
        chk("async_reset_flags", 32'({req_valid, new_req, door_reopen}), 32'd0);
        repeat (3) step();
        RST = 1'b1;
        n = cyc;
        push(n + 1 + LAT, 3'b101, 1'b1, 3'b000);
        at(n + 1 + LAT);
        chk("reset_held_req", 32'(requests), 32'b101);
        step();
        interior_panel = '0;
        exterior_panel = '0;
        repeat (LAT + 4) step();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d outstanding expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
